// File: rtl/seg8_display_arbiter.sv
// rtl/seg8_display_arbiter.sv - round-robin arbiter sharing one seg8 driver between A, B and refresh (option: SEG8_BLANK_LEADING_ZERO_EN)
module seg8_display_arbiter #(
  parameter int unsigned TRIG_CYCLES    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter logic [3:0]  BLANK_CODE     = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [11:0] val_a,
  input  logic        req_b,
  input  logic [11:0] val_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        err,
  output logic        busy,
  output logic        trigger,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  input  logic        load
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRIG = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_B   = 2'd1;
  localparam logic [1:0] SRC_REF = 2'd2;

`ifdef SEG8_BLANK_LEADING_ZERO_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam bit          REF_EN    = (REFRESH_CYCLES != 0);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] REF_LAST  = REF_EN ? 32'(REFRESH_CYCLES - 1) : 32'd0;

  logic [1:0]  state_q, state_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;
  logic [11:0] digits_q, digits_d;
  logic [11:0] last_q, last_d;
  logic [1:0]  src_q, src_d;
  logic        ptr_q, ptr_d;       // 1: B was granted last, so A wins the next tie
  logic        done_q, done_d;
  logic        load_q;
  logic        trigger_q, trigger_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        load_edge;
  logic        grant_b;
  logic        start;

  // Leading-zero blanking; the units digit always shows
  function automatic logic [11:0] blank_lz(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (BLANK_EN && (v[11:8] == 4'd0)) begin
      r[11:8] = BLANK_CODE;
      if (v[7:4] == 4'd0) r[7:4] = BLANK_CODE;
    end
    return r;
  endfunction

  assign load_edge = load & ~load_q;

  // Next-state logic for arbitration, transfer sequencing and timeout
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    digits_d   = digits_q;
    last_d     = last_q;
    src_d      = src_q;
    ptr_d      = ptr_q;
    done_d     = done_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    err_d      = 1'b0;
    grant_b    = req_b && (!req_a || !ptr_q);
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ref_cnt_d = REF_EN ? ref_cnt_q + 32'd1 : 32'd0;
        if (req_a || req_b) begin
          src_d    = grant_b ? SRC_B : SRC_A;
          digits_d = blank_lz(grant_b ? val_b : val_a);
          last_d   = blank_lz(grant_b ? val_b : val_a);
          start    = 1'b1;
        end else if (REF_EN && (ref_cnt_q == REF_LAST)) begin
          src_d    = SRC_REF;
          digits_d = last_q;
          start    = 1'b1;
        end
        if (start) begin
          state_d    = ST_TRIG;
          trig_cnt_d = 32'd0;
          tmo_cnt_d  = 32'd0;
          ref_cnt_d  = 32'd0;
          done_d     = 1'b0;
        end
      end
      ST_TRIG: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (load_edge) done_d = 1'b1;
        if (trig_cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT;
        end else begin
          trig_cnt_d = trig_cnt_q + 32'd1;
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (done_q || load_edge) begin
          state_d = ST_DONE;
          ack_a_d = (src_q == SRC_A);
          ack_b_d = (src_q == SRC_B);
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          if (src_q != SRC_REF) ptr_d = (src_q == SRC_B);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (src_q != SRC_REF) ptr_d = (src_q == SRC_B);
      end
    endcase
    trigger_d = (state_d == ST_TRIG);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any transfer silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      trig_cnt_q <= 32'd0;
      tmo_cnt_q  <= 32'd0;
      ref_cnt_q  <= 32'd0;
      digits_q   <= 12'd0;
      last_q     <= 12'd0;
      src_q      <= SRC_A;
      ptr_q      <= 1'b1;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      trigger_q  <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      digits_q   <= digits_d;
      last_q     <= last_d;
      src_q      <= src_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      load_q     <= load;
      trigger_q  <= trigger_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign trigger = trigger_q;
  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign num2    = digits_q[11:8];
  assign num1    = digits_q[7:4];
  assign num0    = digits_q[3:0];

endmodule

// File: doc/seg8_display_arbiter.md
Name: seg8_display_arbiter

Overview:
Controller that shares one sn74hc595_trio_seg8_driver between two requesters (A and B) and a built-in periodic refresh.
- Grants the driver round-robin and holds num0..num2 stable for the whole transfer.
- Pulses trigger, then treats the driver's load rising edge as transfer completion.
- Acks the winning requester on completion; flags an error on timeout.

Parameters:
TRIG_CYCLES, 5, trigger high time in clk cycles (minimum 1)
TIMEOUT_CYCLES, 4096, cycles from trigger assertion to abort if no load edge arrives
REFRESH_CYCLES, 1000000, idle cycles before the last value is resent; 0 disables refresh
BLANK_CODE, 4'hF, digit code sent for a blanked digit (optional feature only)

Ports:
clk  in  1  system clock; the driver uses the same clock
rst_n  in  1  reset, asynchronous, active-low
req_a  in  1  requester A level request; held until ack_a
val_a  in  12  A digits, BCD: [11:8] hundreds, [7:4] tens, [3:0] units
req_b  in  1  requester B level request; held until ack_b
val_b  in  12  B digits, same layout as val_a
ack_a  out  1  one-cycle pulse: A's value has been loaded into the display
ack_b  out  1  one-cycle pulse: B's value has been loaded into the display
err  out  1  one-cycle pulse: transfer timed out
busy  out  1  high in every state except IDLE
trigger  out  1  to driver trigger input
num0  out  4  to driver num0 (units)
num1  out  4  to driver num1 (tens)
num2  out  4  to driver num2 (hundreds)
load  in  1  from driver load output; the rising edge marks completion

Behaviour:
- Reset (async, rst_n=0):
  - trigger, ack_a, ack_b, err and busy = 0.
  - num0..num2 = 0; last value register = 0.
  - Grant pointer = B, so A wins the first tie.
  - Refresh and timeout counters = 0; FSM goes to IDLE; load_d = 0.
  - Reset mid-transfer aborts silently: no ack and no err.
- All outputs are registered.
- load edge detect: load_d <= load; edge = load & ~load_d.
- FSM states: IDLE, TRIG, WAIT, DONE.
- IDLE:
  - If req_a or req_b is high, grant round-robin: the requester not granted last wins; a lone requester wins.
  - On grant: latch its value into num2/num1/num0 and the last value register, record the source, go to TRIG.
  - Else, if refresh is enabled and the refresh counter reaches REFRESH_CYCLES-1: reload num* from the last value register, source = REFRESH, go to TRIG.
  - A request and refresh expiry in the same cycle: the request wins.
  - The refresh counter clears whenever the FSM leaves IDLE.
- TRIG:
  - trigger=1 for exactly TRIG_CYCLES cycles, then go to WAIT with trigger=0.
  - A load edge seen during TRIG sets the done flag.
- WAIT:
  - Done flag set, or load edge this cycle -> DONE.
  - Timeout counter (started at TRIG entry) reaches TIMEOUT_CYCLES-1 -> err=1 for one cycle, go to IDLE, no ack, grant pointer still advances.
  - Load edge and timeout in the same cycle: completion wins, no err.
- DONE (1 cycle): pulse ack_a or ack_b per source (none for REFRESH), update the grant pointer (not for REFRESH), go to IDLE.
- num* are stable from TRIG entry until the next grant; they never change while busy=1.
- Requester deasserting req mid-transfer: the transfer still completes and the ack still pulses.
- A req still high in the cycle after its ack is a new request.
- Load edges while in IDLE are ignored.
- Latency from idle to trigger: req sampled in cycle N -> trigger high in N+1.
- Ack timing: ack fires one cycle after the WAIT cycle that detects completion.

Optional Feature:
SEG8_BLANK_LEADING_ZERO_EN
- Defined: when the value is latched, leading zero digits are replaced by BLANK_CODE.
  - Hundreds=0 -> num2=BLANK_CODE.
  - Hundreds=0 and tens=0 -> num1=BLANK_CODE as well.
  - Units are never blanked.
  - The last value register stores the blanked form, so refresh resends it.
- Not defined: digits pass through unmodified; BLANK_CODE is unused.

Test Plan:
1. Reset, then req_a=1 with val_a=12'h345 -> trigger high for 5 cycles; num2/num1/num0 = 3/4/5; model driver raises load -> ack_a pulses one cycle; busy falls.
2. req_a and req_b high together from reset, val_b=12'h789 -> A served first, then B (num=7/8/9, ack_b); a second tie is served B first.
3. Request with load held low -> err pulses at TIMEOUT_CYCLES after the trigger rise; no ack; busy=0; next request proceeds normally.
4. REFRESH_CYCLES=50, no requests after a transfer of 12'h123 -> trigger re-fires with 1/2/3 after 50 idle cycles, with no ack; a req_b in the expiry cycle is served instead.
5. rst_n pulsed low during WAIT -> outputs clear immediately; no ack or err; a fresh req_a completes.
6. With SEG8_BLANK_LEADING_ZERO_EN defined, val_a=12'h007 -> num2=F, num1=F, num0=7; val_a=12'h000 -> F/F/0.
